// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM peripheral.
// Provides the register offsets within the PWM page and the CTRL bit positions.
package pwm_pkg;

   localparam int unsigned ADDR_W = 12;
   localparam int unsigned DATA_W = 32;

   localparam logic [ADDR_W-1:0] CTRL_OFS     = 12'h000;
   localparam logic [ADDR_W-1:0] PERIOD_OFS   = 12'h004;
   localparam logic [ADDR_W-1:0] PRESCALE_OFS = 12'h008;
   localparam logic [ADDR_W-1:0] CMP_BASE     = 12'h010;

   localparam int unsigned CTRL_EN_BIT  = 0;
   localparam int unsigned CTRL_POL_LSB = 16;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, period counter and the shadow copies of
// PERIOD and PRESCALE, plus tick and wrap generation.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   en              channel enable; when low the counters are held at zero
//   period          written PERIOD register value
//   prescale        written PRESCALE register value
//   count           current counter value
//   load_c          shadow load strobe (wrap event, or every cycle while disabled)
//   wrap            registered one-cycle pulse after the counter wraps
module pwm_timebase #(
   parameter int unsigned CNT_W = 12,
   parameter int unsigned PRE_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   input  logic [PRE_W-1:0] prescale,
   output logic [CNT_W-1:0] count,
   output logic             load_c,
   output logic             wrap
);

   logic [PRE_W-1:0] pre_q;
   logic [PRE_W-1:0] pre_sh;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] per_sh;
   logic             tick_c;
   logic             wrap_ev_c;

   // Tick when the prescaler reaches its shadowed limit; wrap when the counter
   // is at its shadowed period on that tick.
   always_comb begin
      tick_c    = (pre_q == pre_sh);
      wrap_ev_c = en & tick_c & (cnt_q == per_sh);
      load_c    = wrap_ev_c | ~en;
   end

   // Counters, shadows and registered wrap pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         pre_q  <= '0;
         cnt_q  <= '0;
         pre_sh <= '0;
         per_sh <= '1;
         wrap   <= 1'b0;
      end else begin
         wrap <= wrap_ev_c;
         if (load_c) begin
            pre_sh <= prescale;
            per_sh <= period;
         end
         if (!en) begin
            pre_q <= '0;
            cnt_q <= '0;
         end else begin
            pre_q <= tick_c ? '0 : pre_q + PRE_W'(1);
            if (tick_c) begin
               cnt_q <= (cnt_q == per_sh) ? '0 : cnt_q + CNT_W'(1);
            end
         end
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/pwm_multi.sv
// Memory-mapped multi-channel PWM peripheral: register file, read mux,
// double-buffered compare registers and per-channel comparators.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   CS_N, WR_N   active-low chip select and write strobe
//   Addr         byte offset within the PWM page
//   DataIn       write data
//   DataOut      combinational read data (0 when not selected)
//   PWM_OUT      registered channel outputs (bit 0 drives the board LED)
//   WRAP         one-cycle pulse after the counter wraps
module pwm_multi
   import pwm_pkg::*;
#(
   parameter int unsigned NCH   = 4,
   parameter int unsigned CNT_W = 12,
   parameter int unsigned PRE_W = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              CS_N,
   input  logic              WR_N,
   input  logic [11:0]       Addr,
   input  logic [31:0]       DataIn,
   output logic [31:0]       DataOut,
   output logic [NCH-1:0]    PWM_OUT,
   output logic              WRAP
);

   localparam int unsigned WORD_W = ADDR_W - 2;

   logic             en_q;
   logic [NCH-1:0]   pol_q;
   logic [CNT_W-1:0] period_q;
   logic [PRE_W-1:0] prescale_q;
   logic [CNT_W-1:0] cmp_q  [NCH];
   logic [CNT_W-1:0] cmp_sh [NCH];

   logic              wr_c;
   logic [ADDR_W-1:0] cmp_off_c;
   logic [WORD_W-1:0] cmp_word_c;
   logic              cmp_hit_c;
   logic [CNT_W-1:0]  count;
   logic              load_c;
   logic              unused_ok;

   // Write strobe and compare-bank address decode.
   always_comb begin
      wr_c       = ~CS_N & ~WR_N;
      cmp_off_c  = Addr - CMP_BASE;
      cmp_word_c = cmp_off_c[ADDR_W-1:2];
      cmp_hit_c  = (Addr >= CMP_BASE) && (Addr[1:0] == 2'b00) &&
                   (cmp_word_c < WORD_W'(NCH));
   end

   assign unused_ok = ^{DataIn, cmp_off_c[1:0]};

   pwm_timebase #(
      .CNT_W (CNT_W),
      .PRE_W (PRE_W)
   ) u_timebase (
      .clk      (clk),
      .reset    (reset),
      .en       (en_q),
      .period   (period_q),
      .prescale (prescale_q),
      .count    (count),
      .load_c   (load_c),
      .wrap     (WRAP)
   );

   // Register file; write data is truncated to each field's width.
   always_ff @(posedge clk) begin
      if (reset) begin
         en_q       <= 1'b0;
         pol_q      <= '0;
         period_q   <= '1;
         prescale_q <= '0;
         for (int i = 0; i < int'(NCH); i++) cmp_q[i] <= '0;
      end else if (wr_c) begin
         case (Addr)
            CTRL_OFS: begin
               en_q  <= DataIn[CTRL_EN_BIT];
               pol_q <= DataIn[CTRL_POL_LSB +: NCH];
            end
            PERIOD_OFS:   period_q   <= DataIn[CNT_W-1:0];
            PRESCALE_OFS: prescale_q <= DataIn[PRE_W-1:0];
            default: ;
         endcase
         for (int i = 0; i < int'(NCH); i++) begin
            if (cmp_hit_c && (cmp_word_c == WORD_W'(i))) cmp_q[i] <= DataIn[CNT_W-1:0];
         end
      end
   end

   // Compare shadows follow the timebase load strobe so changes land on period edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < int'(NCH); i++) cmp_sh[i] <= '0;
      end else if (load_c) begin
         for (int i = 0; i < int'(NCH); i++) cmp_sh[i] <= cmp_q[i];
      end
   end

   // Per-channel comparators; polarity is live, disabled channels sit at their inactive level.
   always_ff @(posedge clk) begin
      if (reset) begin
         PWM_OUT <= '0;
      end else begin
         for (int i = 0; i < int'(NCH); i++) begin
            PWM_OUT[i] <= en_q ? ((count < cmp_sh[i]) ^ pol_q[i]) : pol_q[i];
         end
      end
   end

   // Read mux; unmapped offsets and unused bits read as zero.
   always_comb begin
      DataOut = '0;
      if (!CS_N) begin
         case (Addr)
            CTRL_OFS: begin
               DataOut[CTRL_EN_BIT]          = en_q;
               DataOut[CTRL_POL_LSB +: NCH]  = pol_q;
            end
            PERIOD_OFS:   DataOut[CNT_W-1:0] = period_q;
            PRESCALE_OFS: DataOut[PRE_W-1:0] = prescale_q;
            default: ;
         endcase
         for (int i = 0; i < int'(NCH); i++) begin
            if (cmp_hit_c && (cmp_word_c == WORD_W'(i))) DataOut[CNT_W-1:0] = cmp_q[i];
         end
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (NCH=4, CNT_W=12, PRE_W=8). Expected PWM_OUT/WRAP
// values come from a closed-form timeline model and are queued ahead of the cycles
// that produce them; register reads are checked against constants.
module tb_pwm_multi;

   logic        clk = 1'b0;
   logic        reset;
   logic        CS_N;
   logic        WR_N;
   logic [11:0] Addr;
   logic [31:0] DataIn;
   logic [31:0] DataOut;
   logic [3:0]  PWM_OUT;
   logic        WRAP;

   always #5 clk = ~clk;

   pwm_multi #(
      .NCH   (4),
      .CNT_W (12),
      .PRE_W (8)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .CS_N    (CS_N),
      .WR_N    (WR_N),
      .Addr    (Addr),
      .DataIn  (DataIn),
      .DataOut (DataOut),
      .PWM_OUT (PWM_OUT),
      .WRAP    (WRAP)
   );

   int         n_vec = 0;
   int         n_err = 0;
   int         k;
   int         p;
   int         n;
   int         c [4];
   logic [3:0] pol;
   logic [4:0] sb [$];

   // Expected {WRAP, PWM_OUT} after the k-th edge following the enabling write.
   function automatic logic [4:0] model(int kk);
      logic [3:0] o;
      logic       w;
      int         cnt;
      cnt = (kk >= 1) ? (((kk - 1) / (p + 1)) % (n + 1)) : 0;
      for (int i = 0; i < 4; i++) o[i] = ((kk >= 1) && (cnt < c[i])) ^ pol[i];
      w = (kk > 0) && ((kk % ((p + 1) * (n + 1))) == 0);
      return {w, o};
   endfunction

   task automatic push_run(input int k0, input int k1);
      for (int kk = k0; kk <= k1; kk++) sb.push_back(model(kk));
   endtask

   task automatic push_idle(input int cnt);
      for (int i = 0; i < cnt; i++) sb.push_back({1'b0, pol});
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: sample outputs at the falling edge against the queued expectation.
   task automatic cyc();
      logic [4:0] e;
      @(posedge clk);
      k++;
      @(negedge clk);
      n_vec++;
      assert (sb.size() > 0) else begin
         n_err++;
         $error("FAIL sb_empty k=%0d observed=%0d expected=nonzero", k, sb.size());
      end
      if (sb.size() > 0) begin
         n_vec--;
         e = sb.pop_front();
         check($sformatf("out_k%0d", k), {27'b0, WRAP, PWM_OUT}, {27'b0, e});
      end
      CS_N = 1'b1;
      WR_N = 1'b1;
   endtask

   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      CS_N   = 1'b0;
      WR_N   = 1'b0;
      Addr   = a;
      DataIn = d;
      cyc();
   endtask

   task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
      CS_N = 1'b0;
      WR_N = 1'b1;
      Addr = a;
      #1;
      check(tag, DataOut, exp);
      CS_N = 1'b1;
   endtask

   task automatic run_to(input int kt);
      while (k < kt) cyc();
   endtask

   initial begin
      reset  = 1'b1;
      CS_N   = 1'b1;
      WR_N   = 1'b1;
      Addr   = '0;
      DataIn = '0;
      k      = 0;
      p      = 0;
      n      = 0;
      c      = '{0, 0, 0, 0};
      pol    = 4'b0000;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // Reset values and idle outputs
      rd("rst_ctrl", 12'h000, 32'h0);
      rd("rst_period", 12'h004, 32'h0000_0FFF);
      rd("rst_prescale", 12'h008, 32'h0);
      for (int i = 0; i < 4; i++) rd($sformatf("rst_cmp%0d", i), 12'(16 + 4 * i), 32'h0);
      rd("unmapped_00c", 12'h00C, 32'h0);
      CS_N = 1'b1;
      Addr = 12'h004;
      #1;
      check("deselected_read", DataOut, 32'h0);
      push_idle(10);
      repeat (10) cyc();

      // Configuration while disabled, including truncation and an unmapped write
      push_idle(7);
      wr(12'h004, 32'hFFFF_F009);
      wr(12'h008, 32'h0);
      wr(12'h010, 32'd3);
      wr(12'h014, 32'd0);
      wr(12'h018, 32'd10);
      wr(12'h01C, 32'h0000_1005);
      wr(12'h020, 32'h0000_ABCD);
      rd("trunc_period", 12'h004, 32'd9);
      rd("cmp2", 12'h018, 32'd10);
      rd("trunc_cmp3", 12'h01C, 32'd5);
      rd("unmapped_020", 12'h020, 32'h0);

      // Enable, POL change, mid-period and wrap-cycle compare writes, then disable
      p = 0;
      n = 9;
      c = '{3, 0, 10, 5};
      pol = 4'b0000;
      push_run(0, 13);
      pol = 4'b0010;
      push_run(14, 30);
      c[0] = 7;
      push_run(31, 50);
      c[0] = 3;
      push_run(51, 65);
      push_idle(12);
      k = -1;
      wr(12'h000, 32'h0000_0001);
      run_to(12);
      wr(12'h000, 32'h0002_0001);
      rd("ctrl_pol", 12'h000, 32'h0002_0001);
      run_to(23);
      wr(12'h010, 32'd7);
      rd("cmp0_readback", 12'h010, 32'd7);
      run_to(39);
      wr(12'h010, 32'd3);
      run_to(64);
      wr(12'h000, 32'h0002_0000);
      run_to(77);
      rd("ctrl_disabled", 12'h000, 32'h0002_0000);

      // Prescaled timebase: 20-cycle period, channel 0 high for 8 cycles
      push_idle(3);
      wr(12'h008, 32'd3);
      wr(12'h004, 32'd4);
      wr(12'h010, 32'd2);
      p = 3;
      n = 4;
      c[0] = 2;
      push_run(0, 45);
      k = -1;
      wr(12'h000, 32'h0002_0001);
      run_to(45);

      // Synchronous reset in the middle of a run
      pol = 4'b0000;
      push_idle(1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      push_idle(4);
      repeat (4) cyc();
      rd("rerst_ctrl", 12'h000, 32'h0);
      rd("rerst_period", 12'h004, 32'h0000_0FFF);
      rd("rerst_prescale", 12'h008, 32'h0);
      rd("rerst_cmp0", 12'h010, 32'h0);
      rd("rerst_cmp3", 12'h01C, 32'h0);
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
